// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule FSM encoding and GF(2^8) doubling helper.
package aes_pkg;

    localparam int NK = 4;
    localparam int NR = 10;
    localparam int NW = 44;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RED_POLY  = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2
    } ks_state_t;

    // Multiply by x in GF(2^8), reducing modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? RED_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// Four parallel AES S-box lookups on a 32-bit word; also reused by SubBytes.
module aes_subword (
    input  logic [31:0] word,
    output logic [31:0] sub
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign sub = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};

endmodule

// File: rtl/rotword.sv
// Cyclic left rotation of a 32-bit word by one byte.
module rotword (
    input  logic [31:0] word,
    output logic [31:0] rot
);

    assign rot = {word[23:0], word[31:24]};

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key expansion controller: one schedule word per clock over a
// sliding 4-word window, publishing each completed round key as a pulse.
module aes_key_schedule_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] key_in,
    output logic [0:127] round_key,
    output logic         round_key_valid,
    output logic [0:3]   round_idx,
    output logic         busy,
    output logic         done
);

    import aes_pkg::*;

    if (NR != aes_pkg::NR) begin : g_nr_check
        $error("aes_key_schedule_ctrl supports only NR=10 (AES-128)");
    end

    ks_state_t    state_r;
    logic [127:0] win_r;
    logic [5:0]   word_cnt_r;
    logic [7:0]   rcon_r;

    logic [31:0]  w_first_s;
    logic [31:0]  w_last_s;
    logic [31:0]  rot_s;
    logic [31:0]  sub_s;
    logic [31:0]  new_word_s;
    logic [127:0] next_win_s;

    assign w_first_s = win_r[127:96];
    assign w_last_s  = win_r[31:0];

    rotword u_rotword (
        .word (w_last_s),
        .rot  (rot_s)
    );

    aes_subword u_subword (
        .word (rot_s),
        .sub  (sub_s)
    );

    // Next schedule word: the S-box path applies only at the start of each 4-word group.
    always_comb begin
        new_word_s = w_first_s ^ w_last_s;
        if (word_cnt_r[1:0] == 2'b00) begin
            new_word_s = w_first_s ^ sub_s ^ {rcon_r, 24'h000000};
        end else begin
            new_word_s = w_first_s ^ w_last_s;
        end
        next_win_s = {win_r[95:0], new_word_s};
    end

    // Control FSM, schedule window and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            win_r           <= 128'h0;
            word_cnt_r      <= 6'd0;
            rcon_r          <= 8'h00;
            round_key       <= 128'h0;
            round_key_valid <= 1'b0;
            round_idx       <= 4'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    round_key_valid <= 1'b0;
                    done            <= 1'b0;
                    if (start) begin
                        win_r           <= key_in;
                        round_key       <= key_in;
                        round_key_valid <= 1'b1;
                        round_idx       <= 4'd0;
                        busy            <= 1'b1;
                        word_cnt_r      <= 6'(NK);
                        rcon_r          <= RCON_INIT;
                        state_r         <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD, ST_EXPAND: begin
                    round_key_valid <= 1'b0;
                    done            <= 1'b0;
                    // The extra cycle after word 43 keeps start blocked while done is visible.
                    if (word_cnt_r == 6'(NW)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        win_r      <= next_win_s;
                        word_cnt_r <= word_cnt_r + 6'd1;
                        state_r    <= ST_EXPAND;
                        if (word_cnt_r[1:0] == 2'b00) begin
                            rcon_r <= xtime(rcon_r);
                        end else begin
                            rcon_r <= rcon_r;
                        end
                        if (word_cnt_r[1:0] == 2'b11) begin
                            round_key       <= next_win_s;
                            round_key_valid <= 1'b1;
                            round_idx       <= word_cnt_r[5:2];
                            if (word_cnt_r == 6'(NW - 1)) begin
                                done <= 1'b1;
                                busy <= 1'b0;
                            end else begin
                                done <= 1'b0;
                            end
                        end else begin
                            round_key_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    round_key_valid <= 1'b0;
                    busy            <= 1'b0;
                    done            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Randomised self-checking bench: a FIPS-197 style expansion model (S-box built
// from GF inverses) predicts every output cycle by cycle.
module tb_aes_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [0:127] key_in = '0;
    logic [0:127] round_key;
    logic         round_key_valid;
    logic [0:3]   round_idx;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    logic [7:0]   sb [0:255];
    logic [127:0] ek [0:10];
    logic [127:0] m_keys [0:10];
    bit           m_active = 1'b0;
    int           m_k = 0;
    logic [127:0] e_rk = '0;
    logic         e_valid = 1'b0;
    logic         e_busy = 1'b0;
    logic         e_done = 1'b0;
    logic [3:0]   e_idx = '0;
    logic [7:0]   rcon_lit [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_key_schedule_ctrl #(.NR(10)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .key_in          (key_in),
        .round_key       (round_key),
        .round_key_valid (round_key_valid),
        .round_idx       (round_idx),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            end
            sb[x] = s;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) ek[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model advanced on every clock, then compared with the DUT just after the edge.
    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            e_rk = '0; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_idx = '0;
        end else begin
            if (m_active) m_k++;
            if (start && (!m_active || m_k >= 42)) begin
                expand(key_in);
                for (int r = 0; r < 11; r++) m_keys[r] = ek[r];
                m_active = 1'b1;
                m_k = 0;
            end else if (m_active && m_k >= 42) begin
                m_active = 1'b0;
            end
            e_valid = 1'b0; e_done = 1'b0; e_busy = 1'b0;
            if (m_active && m_k <= 40) begin
                e_busy = (m_k < 40);
                if (m_k % 4 == 0) begin
                    e_valid = 1'b1;
                    e_idx = 4'(m_k / 4);
                    e_rk = m_keys[m_k / 4];
                    e_done = (m_k == 40);
                end
            end
        end
        #1;
        check("round_key", round_key, e_rk);
        check("round_key_valid", 128'(round_key_valid), 128'(e_valid));
        check("round_idx", 128'(round_idx), 128'(e_idx));
        check("busy", 128'(busy), 128'(e_busy));
        check("done", 128'(done), 128'(e_done));
        if (round_key_valid) vcount++;
        if (m_active && m_k % 4 == 0 && m_k <= 36) check("rcon", 128'(dut.rcon_r), 128'(rcon_lit[m_k / 4]));
    end

    initial begin
        build_sbox();
        check("model_sbox_00", 128'(sb[0]), 128'h63);
        check("model_sbox_53", 128'(sb[8'h53]), 128'hed);
        expand(FIPS_KEY);
        check("model_fips_r1", ek[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("model_fips_r10", ek[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        expand(128'h0);
        check("model_zero_r1", ek[1], 128'h62636363626363636263636362636363);
        check("model_zero_r10", ek[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        rst = 1'b1; start = 1'b0; key_in = '0;
        step(3);
        rst = 1'b0;
        step(2);

        // FIPS key with start re-asserted at cycles 3 and 20 using other keys.
        key_in = FIPS_KEY; start = 1'b1;
        step(1);
        start = 1'b0; key_in = {$urandom, $urandom, $urandom, $urandom};
        step(2);
        start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
        step(1);
        start = 1'b0;
        step(16);
        start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
        step(1);
        start = 1'b0;
        step(25);

        // All-zero key: exactly eleven pulses.
        vcount = 0;
        key_in = '0; start = 1'b1;
        step(1);
        start = 1'b0;
        step(46);
        check("pulse_count", 128'(vcount), 128'd11);

        // Reset at cycle 17, fresh start at cycle 19.
        key_in = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1;
        step(1);
        start = 1'b0;
        step(16);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        key_in = FIPS_KEY; start = 1'b1;
        step(1);
        start = 1'b0;
        step(45);

        // Back-to-back: second start held from cycle 40.
        key_in = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1;
        step(1);
        start = 1'b0;
        step(39);
        key_in = FIPS_KEY; start = 1'b1;
        step(3);
        start = 1'b0;
        step(45);

        // Random starts, keys and occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 5) == 0);
            key_in = {$urandom, $urandom, $urandom, $urandom};
            step(1);
        end
        rst = 1'b0; start = 1'b0;
        step(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
